logic_op_pipe: RTL and testbench

LOGIC_OP_PIPE -- requirements
Module: logic_op_pipe

---
 rtl/logic_op_pipe.sv | 75 +++++++
 tb/tb_logic_op_pipe.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/logic_op_pipe.sv
// logic_op_pipe: two-stage valid/ready pipeline computing a bitwise AND/OR/XOR/NAND
// of two operands, with a zero flag and a saturating delivered-result counter.
module logic_op_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             c_zero,
    output logic [CNT_W-1:0] txn_count
);
    logic             s1_valid_q;
    logic [1:0]       s1_op_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic             s2_valid_q;
    logic [WIDTH-1:0] c_q, c_d;
    logic             c_zero_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_load, s2_load, out_xfer;

    assign s2_load   = !s2_valid_q || out_ready;
    assign s1_load   = !s1_valid_q || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid_q;
    assign c         = c_q;
    assign c_zero    = c_zero_q;
    assign txn_count = cnt_q;
    assign out_xfer  = s2_valid_q && out_ready;

    always_comb begin
        c_d   = s1_op_q == 2'd0 ? (s1_a_q & s1_b_q) :
                s1_op_q == 2'd1 ? (s1_a_q | s1_b_q) :
                s1_op_q == 2'd2 ? (s1_a_q ^ s1_b_q) : ~(s1_a_q & s1_b_q);
        cnt_d = (out_xfer && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= 2'd0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            c_q        <= '0;
            c_zero_q   <= 1'b1;
            cnt_q      <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    c_q      <= c_d;
                    c_zero_q <= c_d == '0;
                end
            end
            // operands only captured on a real input transfer
            if (s1_load) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_op_q <= op;
                    s1_a_q  <= a;
                    s1_b_q  <= b;
                end
            end
        end
    end
endmodule

// File: tb/tb_logic_op_pipe.sv
// tb_logic_op_pipe: directed and randomized checks of logic_op_pipe (WIDTH=8, CNT_W=4).
module tb_logic_op_pipe;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] op = 2'd0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] c;
    logic       c_zero;
    logic [3:0] txn_count;

    int checks = 0;
    int errors = 0;

    logic_op_pipe #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .c_zero(c_zero), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            2'd0: return x & y;
            2'd1: return x | y;
            2'd2: return x ^ y;
            default: return ~(x & y);
        endcase
    endfunction

    initial begin
        logic [7:0] exp4 [4];
        logic [7:0] q [$];
        logic [7:0] held;
        int accepts;
        int delivered;
        exp4 = '{8'h0C, 8'h3F, 8'h33, 8'hF3};

        step(); step();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_c", c, 8'h00);
        check("rst_c_zero", c_zero, 1);
        check("rst_txn", txn_count, 0);
        check("rst_in_ready", in_ready, 1);

        // four ops back-to-back, no backpressure
        out_ready = 1'b1;
        a = 8'h0F; b = 8'h3C;
        for (int k = 0; k < 6; k++) begin
            in_valid = k < 4;
            op = 2'(k);
            step();
            if (k == 0 || k == 5) check($sformatf("seq_valid%0d", k), out_valid, 0);
            else begin
                check($sformatf("seq_valid%0d", k), out_valid, 1);
                check($sformatf("seq_c%0d", k), c, exp4[k-1]);
            end
        end
        check("seq_txn", txn_count, 4);

        // all-zero result
        in_valid = 1'b1; a = 8'hAA; b = 8'h55; op = 2'd0;
        step();
        in_valid = 1'b0;
        step();
        check("zero_valid", out_valid, 1);
        check("zero_c", c, 8'h00);
        check("zero_flag", c_zero, 1);
        step();
        check("zero_txn", txn_count, 5);

        // backpressure: only two entries fit
        out_ready = 1'b0; in_valid = 1'b1; op = 2'd1; b = 8'h00;
        accepts = 0;
        for (int i = 0; i < 5; i++) begin
            a = 8'h10 + 8'(i);
            #1;
            if (in_ready) accepts++;
            step();
            if (i >= 2) check($sformatf("stall_c%0d", i), c, 8'h10);
        end
        check("stall_accepts", accepts, 2);
        check("stall_in_ready", in_ready, 0);
        check("stall_valid", out_valid, 1);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("drain_valid", out_valid, 1);
        check("drain_c", c, 8'h11);
        step();
        check("drain_empty", out_valid, 0);
        check("drain_txn", txn_count, 7);

        // saturation
        in_valid = 1'b1; op = 2'd2; a = 8'h01; b = 8'h02;
        for (int i = 0; i < 20; i++) step();
        in_valid = 1'b0;
        step(); step(); step();
        check("sat_txn", txn_count, 15);

        // reset with both stages full
        out_ready = 1'b0; in_valid = 1'b1; op = 2'd1; a = 8'h5A; b = 8'h00;
        step(); step(); step();
        check("full_in_ready", in_ready, 0);
        check("full_valid", out_valid, 1);
        rst = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check("mrst_valid", out_valid, 0);
        check("mrst_c", c, 8'h00);
        check("mrst_c_zero", c_zero, 1);
        check("mrst_txn", txn_count, 0);
        check("mrst_in_ready", in_ready, 1);
        step();
        check("mrst_stays_empty", out_valid, 0);

        // random traffic against a scoreboard
        delivered = 0;
        held = 8'h00;
        for (int i = 0; i < 1030; i++) begin
            logic stalled;
            in_valid  = i < 1000 ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready = i < 1000 ? 1'($urandom_range(0, 3) != 0) : 1'b1;
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            b  = 8'($urandom);
            #1;
            if (in_valid && in_ready) q.push_back(model(op, a, b));
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("sb_extra", out_valid, 0);
                else begin
                    logic [7:0] e;
                    e = q.pop_front();
                    check($sformatf("sb_c%0d", i), c, e);
                    check($sformatf("sb_z%0d", i), c_zero, e == 8'h00);
                end
                delivered++;
            end
            stalled = out_valid && !out_ready;
            held = c;
            step();
            if (stalled) begin
                check($sformatf("hold_v%0d", i), out_valid, 1);
                check($sformatf("hold_c%0d", i), c, held);
            end
        end
        check("sb_drained", q.size(), 0);
        check("rand_txn", txn_count, delivered > 15 ? 15 : delivered);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
